// File: rtl/sm83_bus_pkg.sv
// Shared types for the SM83 memory-bus controller: FSM states, default wait
// limit and the per-machine-cycle request snapshot.
package sm83_bus_pkg;

    localparam int MAX_WAIT_DEF = 15;

    typedef enum logic [1:0] {RUN, WAIT, HOLD, HALT} bus_state_t;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic        write;
        logic        idle;
        logic        m1;
    } cyc_reg_t;

endpackage

// File: rtl/sm83_wait_timer.sv
// Wait-state counter: loads 1 when a wait begins, counts while the bus is
// stretched, and flags when the configured limit is reached.
module sm83_wait_timer #(
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              run,
    output logic              expired,
    output logic [WAIT_W-1:0] count
);

    logic [WAIT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset)
            r_count <= '0;
        else if (start)
            r_count <= WAIT_W'(1);
        else if (run && !expired)
            r_count <= r_count + WAIT_W'(1);
        else if (!run)
            r_count <= '0;
    end

    assign count   = r_count;
    assign expired = (r_count == WAIT_W'(MAX_WAIT));

endmodule

// File: rtl/sm83_bus_ctrl.sv
// SM83 bus controller: turns sequencer T-phases into external bus strobes and
// paces the sequencer through ncyc (wait states, bus hold, halt).
module sm83_bus_ctrl
    import sm83_bus_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEF,
    parameter int WAIT_W   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        t1,
    input  logic        t2,
    input  logic        t3,
    input  logic        t4,
    input  logic        m1,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    input  logic        req_write,
    input  logic        req_idle,
    input  logic        halt,
    input  logic        wake,
    input  logic        hold_req,
    input  logic [7:0]  ext_rdata,
    input  logic        ext_wait,
    output logic        ncyc,
    output logic [15:0] ext_addr,
    output logic [7:0]  ext_wdata,
    output logic        ext_mreq,
    output logic        ext_rd,
    output logic        ext_wr,
    output logic        ext_m1,
    output logic        hold_ack,
    output logic [7:0]  rdata,
    output logic        rdata_valid,
    output logic        wait_timeout,
    output logic        halted
);

    bus_state_t        r_state, w_next;
    cyc_reg_t          r_cyc;
    logic              r_halt_ret, w_halt_ret;
    logic              w_done, w_force, w_start_wait, w_expired;
    logic [WAIT_W-1:0] w_count;

    sm83_wait_timer #(.MAX_WAIT(MAX_WAIT), .WAIT_W(WAIT_W)) u_wait (
        .clk     (clk),
        .reset   (reset),
        .start   (w_start_wait),
        .run     ((r_state == WAIT) && !w_done),
        .expired (w_expired),
        .count   (w_count)
    );

    always_comb begin
        w_next       = r_state;
        w_halt_ret   = r_halt_ret;
        ncyc         = 1'b0;
        w_done       = 1'b0;
        w_force      = 1'b0;
        w_start_wait = 1'b0;
        if (reset) begin
            ncyc = 1'b1;
        end else begin
            case (r_state)
                RUN: if (t4) begin
                    if (!r_cyc.idle && ext_wait) begin
                        w_next       = WAIT;
                        w_start_wait = 1'b1;
                    end else begin
                        w_done = 1'b1;
                    end
                end
                // A zeroed counter in WAIT cannot occur legitimately; finish rather than hang.
                WAIT: if (!ext_wait || w_expired || w_count == '0) begin
                    w_done  = 1'b1;
                    w_force = ext_wait;
                end
                HOLD: begin
                    if (wake)
                        w_halt_ret = 1'b0;
                    if (!hold_req) begin
                        if (r_halt_ret && !wake) begin
                            w_next = HALT;
                        end else begin
                            w_next = RUN;
                            ncyc   = 1'b1;
                        end
                    end
                end
                HALT: begin
                    if (hold_req) begin
                        w_next     = HOLD;
                        w_halt_ret = !wake;
                    end else if (wake) begin
                        w_next = RUN;
                        ncyc   = 1'b1;
                    end
                end
                default: w_next = RUN;
            endcase
            if (w_done) begin
                if (hold_req) begin
                    w_next     = HOLD;
                    w_halt_ret = halt;
                end else if (halt) begin
                    w_next = HALT;
                end else begin
                    w_next = RUN;
                    ncyc   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= RUN;
            r_cyc        <= '0;
            r_halt_ret   <= 1'b0;
            ext_addr     <= '0;
            ext_wdata    <= '0;
            ext_mreq     <= 1'b0;
            ext_rd       <= 1'b0;
            ext_wr       <= 1'b0;
            ext_m1       <= 1'b0;
            hold_ack     <= 1'b0;
            rdata        <= '0;
            rdata_valid  <= 1'b0;
            wait_timeout <= 1'b0;
            halted       <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_halt_ret  <= w_halt_ret;
            hold_ack    <= (w_next == HOLD);
            halted      <= (w_next == HALT);
            rdata_valid <= 1'b0;
            if (w_force)
                wait_timeout <= 1'b1;
            if (r_state == RUN && t1) begin
                r_cyc     <= '{addr: req_addr, wdata: req_wdata, write: req_write,
                               idle: req_idle, m1: m1};
                ext_addr  <= req_idle ? 16'h0 : req_addr;
                ext_wdata <= (!req_idle && req_write) ? req_wdata : 8'h0;
                ext_mreq  <= !req_idle;
                ext_rd    <= !req_idle && !req_write;
                ext_m1    <= !req_idle && m1;
            end
            if (r_state == RUN && t2 && !r_cyc.idle && r_cyc.write)
                ext_wr <= 1'b1;
            if (w_done) begin
                ext_addr  <= '0;
                ext_wdata <= '0;
                ext_mreq  <= 1'b0;
                ext_rd    <= 1'b0;
                ext_wr    <= 1'b0;
                ext_m1    <= 1'b0;
                if (!r_cyc.idle && !r_cyc.write) begin
                    rdata       <= ext_rdata;
                    rdata_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sm83_bus_ctrl.sv
// Bench for sm83_bus_ctrl: a behavioural sequencer drives T-phases from ncyc,
// a vector table describes bus cycles, read data flows through a scoreboard.
module tb_sm83_bus_ctrl;

    logic        clk = 1'b0, reset = 1'b1;
    logic        t1, t2, t3, t4, m1 = 1'b0;
    logic [15:0] req_addr = '0;
    logic [7:0]  req_wdata = '0, ext_rdata = '0;
    logic        req_write = 1'b0, req_idle = 1'b0, halt = 1'b0, wake = 1'b0;
    logic        hold_req = 1'b0, ext_wait = 1'b0;
    logic        ncyc, ext_mreq, ext_rd, ext_wr, ext_m1, hold_ack;
    logic        rdata_valid, wait_timeout, halted;
    logic [15:0] ext_addr;
    logic [7:0]  ext_wdata, rdata;

    always #5 clk = ~clk;

    // Sequencer model: t1..t4, then T-idle until ncyc is seen.
    logic [2:0] ph = 3'd0;
    assign t1 = (ph == 3'd1);
    assign t2 = (ph == 3'd2);
    assign t3 = (ph == 3'd3);
    assign t4 = (ph == 3'd4);
    always @(posedge clk) begin
        if (reset)                      ph <= 3'd1;
        else if (ph == 3'd0 || ph == 3'd4) ph <= ncyc ? 3'd1 : 3'd0;
        else                            ph <= ph + 3'd1;
    end

    sm83_bus_ctrl #(.MAX_WAIT(15), .WAIT_W(4)) dut (
        .clk(clk), .reset(reset), .t1(t1), .t2(t2), .t3(t3), .t4(t4), .m1(m1),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_write(req_write),
        .req_idle(req_idle), .halt(halt), .wake(wake), .hold_req(hold_req),
        .ext_rdata(ext_rdata), .ext_wait(ext_wait), .ncyc(ncyc),
        .ext_addr(ext_addr), .ext_wdata(ext_wdata), .ext_mreq(ext_mreq),
        .ext_rd(ext_rd), .ext_wr(ext_wr), .ext_m1(ext_m1), .hold_ack(hold_ack),
        .rdata(rdata), .rdata_valid(rdata_valid), .wait_timeout(wait_timeout),
        .halted(halted)
    );

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic        write, idle, m1;
        logic [7:0]  rdat;
        int          nwait;    // ext_wait held from t4 for this many clocks
        int          exp_len;  // clocks from t1 to the ncyc clock
        logic        exp_to;   // wait_timeout expected afterwards
    } vec_t;

    vec_t       tbl[10];
    int         n_chk = 0, n_err = 0;
    logic [7:0] sbq[$];
    logic [7:0] cur_rdata = 8'h00;
    logic       exp_rdv_next = 1'b0, to_sticky = 1'b0;

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0b want %0b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h want %02h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %04h want %04h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic sb_chk();
        if (exp_rdv_next && sbq.size() != 0)
            cur_rdata = sbq.pop_front();
        chk1("rdata_valid", rdata_valid, exp_rdv_next);
        chk8("rdata", rdata, cur_rdata);
        exp_rdv_next = 1'b0;
    endtask

    task automatic bus_quiet(input string nm);
        chk1({nm, "_mreq"}, ext_mreq, 1'b0);
        chk1({nm, "_rd"}, ext_rd, 1'b0);
        chk1({nm, "_wr"}, ext_wr, 1'b0);
        chk1({nm, "_m1"}, ext_m1, 1'b0);
        chk16({nm, "_addr"}, ext_addr, 16'h0);
        chk8({nm, "_wdata"}, ext_wdata, 8'h0);
    endtask

    task automatic rst_chk();
        chk1("rst_ncyc", ncyc, 1'b1);
        bus_quiet("rst");
        chk1("rst_hold_ack", hold_ack, 1'b0);
        chk1("rst_timeout", wait_timeout, 1'b0);
        chk1("rst_halted", halted, 1'b0);
        sb_chk();
    endtask

    // One machine cycle from t1; optional hold raised in t3, halt at completion,
    // or reset asserted at clock index rst_at.
    task automatic run_txn(input vec_t v, input logic hold_mid, input logic halt_end,
                           input int rst_at);
        int   kc;
        logic bus;
        kc = v.exp_len - 1;
        for (int k = 0; k <= kc; k++) begin
            @(negedge clk);
            reset = 1'b0;
            if (k == 0) begin
                req_addr = v.addr; req_wdata = v.wdata; req_write = v.write;
                req_idle = v.idle; m1 = v.m1;
            end else begin
                req_addr = ~v.addr; req_wdata = ~v.wdata; req_write = ~v.write;
                req_idle = ~v.idle; m1 = ~v.m1;
            end
            ext_wait  = (k >= 3) && ((k - 3) < v.nwait);
            ext_rdata = v.rdat;
            hold_req  = hold_mid && (k >= 2);
            halt      = halt_end && (k == kc);
            wake      = 1'b0;
            if (k == rst_at) reset = 1'b1;
            #1;
            if (k == 0) chk1("t1_start", t1, 1'b1);
            if (k == rst_at) begin
                chk1("ncyc_in_reset", ncyc, 1'b1);
                sb_chk();
                return;
            end
            bus = !v.idle && (k >= 1);
            chk1("ncyc", ncyc, (k == kc) && !hold_mid && !halt_end);
            chk1("mreq", ext_mreq, bus);
            chk1("rd", ext_rd, bus && !v.write);
            chk1("wr", ext_wr, bus && v.write && (k >= 2));
            chk1("ext_m1", ext_m1, bus && v.m1);
            chk16("addr", ext_addr, bus ? v.addr : 16'h0);
            chk8("wdata", ext_wdata, (bus && v.write) ? v.wdata : 8'h0);
            chk1("hold_ack", hold_ack, 1'b0);
            chk1("halted", halted, 1'b0);
            chk1("wait_timeout", wait_timeout, to_sticky);
            sb_chk();
        end
        if (!v.idle && !v.write) begin
            sbq.push_back(v.rdat);
            exp_rdv_next = 1'b1;
        end
        if (v.exp_to) to_sticky = 1'b1;
    endtask

    // HALT entry, hold out of HALT (returns to HALT), then hold+wake (returns to RUN).
    logic hh_hold[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic hh_wake[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic hh_ncyc[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic hh_ack[8]   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic hh_halt[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        tbl[0] = '{16'h1234, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5,   0,  4, 1'b0};
        tbl[1] = '{16'hC000, 8'h3C, 1'b1, 1'b0, 1'b0, 8'h00,   3,  7, 1'b0};
        tbl[2] = '{16'h0000, 8'h00, 1'b0, 1'b1, 1'b0, 8'hEE,   3,  4, 1'b0};
        tbl[3] = '{16'h8001, 8'h00, 1'b0, 1'b0, 1'b0, 8'h5A,   1,  5, 1'b0};
        tbl[4] = '{16'hFFFF, 8'h81, 1'b1, 1'b0, 1'b0, 8'h00,   0,  4, 1'b0};
        tbl[5] = '{16'h4242, 8'h00, 1'b0, 1'b0, 1'b1, 8'h99,   0,  4, 1'b0};
        tbl[6] = '{16'h0150, 8'h00, 1'b0, 1'b0, 1'b1, 8'h3E,   0,  4, 1'b0};
        tbl[7] = '{16'hBEEF, 8'h00, 1'b0, 1'b0, 1'b0, 8'hC3, 100, 19, 1'b1};
        tbl[8] = '{16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 8'hFF,   0,  4, 1'b0};
        tbl[9] = '{16'h2000, 8'h77, 1'b1, 1'b0, 1'b0, 8'h00,  10, 14, 1'b0};

        repeat (3) @(negedge clk);
        #1 rst_chk();

        for (int i = 0; i <= 4; i++) run_txn(tbl[i], 1'b0, 1'b0, -1);

        // Hold raised in t3 of a read: held 5 clocks, released on the 6th.
        run_txn(tbl[5], 1'b1, 1'b0, -1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            hold_req = (i < 5);
            #1;
            chk1("hold_ack_on", hold_ack, 1'b1);
            chk1("hold_ncyc", ncyc, i == 5);
            bus_quiet("hold");
            sb_chk();
        end
        run_txn(tbl[6], 1'b0, 1'b0, -1);

        // Halt at completion, wake on the 10th halted clock, fetch resumes.
        run_txn(tbl[5], 1'b0, 1'b1, -1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            halt = 1'b0;
            wake = (i == 9);
            #1;
            chk1("halted_on", halted, 1'b1);
            chk1("halt_ncyc", ncyc, i == 9);
            chk1("halt_hold_ack", hold_ack, 1'b0);
            bus_quiet("halt");
            sb_chk();
        end
        run_txn(tbl[6], 1'b0, 1'b0, -1);

        run_txn(tbl[3], 1'b0, 1'b1, -1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            halt = 1'b0;
            hold_req = hh_hold[i];
            wake = hh_wake[i];
            #1;
            chk1("hh_ncyc", ncyc, hh_ncyc[i]);
            chk1("hh_hold_ack", hold_ack, hh_ack[i]);
            chk1("hh_halted", halted, hh_halt[i]);
            bus_quiet("hh");
            sb_chk();
        end

        run_txn(tbl[7], 1'b0, 1'b0, -1);
        run_txn(tbl[8], 1'b0, 1'b0, -1);

        // Reset while stretched in WAIT.
        run_txn(tbl[9], 1'b0, 1'b0, 6);
        to_sticky    = 1'b0;
        exp_rdv_next = 1'b0;
        cur_rdata    = 8'h00;
        sbq.delete();
        @(negedge clk);
        ext_wait = 1'b0;
        #1 rst_chk();
        run_txn(tbl[0], 1'b0, 1'b0, -1);
        run_txn(tbl[4], 1'b0, 1'b0, -1);

        @(negedge clk);
        #1 sb_chk();
        chk1("sb_drained", sbq.size() == 0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
